io_input_port: RTL and testbench

- Memory-mapped input peripheral on the IO bus page, selected by addr[8]=1; it is the read-side counterpart of the LED/HEX output registers.
- Synchronises and debounces raw KEY[3:0] and SW[9:0], then presents clean levels to the CPU.
- Captures key press/release and switch-change events in a sticky, write-1-to-clear register, so software polling at low CPU clock rates cannot miss a short press.
- rdata feeds the top-level IO read mux.

---
 rtl/io_map_pkg.sv | 34 +++
 rtl/io_debounce.sv | 55 +++++
 rtl/io_input_port.sv | 132 +++++++++++++
 tb/tb_io_input_port.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_map_pkg
// Purpose  : Shared address map, event bit layout and reset idle levels for
//            the IO input port.
// Contents : IO page select bit, register select bits, event bit positions,
//            reset idle constants for KEY and SW.
// Revision : 1.0  initial release
// ============================================================================
package io_map_pkg;

    // Address decode: the IO page, then a one-hot register select.
    localparam int IO_PAGE_BIT = 8;
    localparam int SEL_KEY     = 4;
    localparam int SEL_SW      = 5;
    localparam int SEL_EVT     = 6;
    localparam int SEL_MASK    = 7;

    // Event register layout: {sw_chg, key_rel[3:0], key_prs[3:0]}.
    localparam int EVT_PRS_LO  = 0;
    localparam int EVT_REL_LO  = 4;
    localparam int EVT_CHG     = 8;
    localparam int EVT_W       = 9;

    localparam int NUM_KEY     = 4;
    localparam int NUM_SW      = 10;
    localparam int NUM_CH      = NUM_KEY + NUM_SW;

    // Idle levels: keys are active-low (released = 1), switches rest at 0.
    localparam logic [NUM_KEY-1:0] KEY_IDLE = 4'hF;
    localparam logic [NUM_SW-1:0]  SW_IDLE  = 10'h000;

endpackage : io_map_pkg
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// ============================================================================
// Module   : io_debounce
// Purpose  : Single-bit two-flop synchroniser followed by a stability-count
//            debouncer. The debounced level only follows the synchronised
//            input after it has differed for DB_CYCLES consecutive clocks.
// Ports    : clk   - system clock
//            reset - asynchronous active-low reset
//            raw   - raw asynchronous input
//            db    - debounced, synchronous output
// Params   : DB_CYCLES (1..255), DB_CNT_W (DB_CYCLES < 2**DB_CNT_W),
//            IDLE (reset level of the synchroniser and output)
// Revision : 1.0  initial release
// ============================================================================
module io_debounce #(
    parameter int   DB_CYCLES = 3,
    parameter int   DB_CNT_W  = 8,
    parameter logic IDLE      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

    logic                sync1;
    logic                sync2;
    logic [DB_CNT_W-1:0] cnt;

    // The counter measures how long sync2 has disagreed with db; any agreement
    // (including a bounce back) restarts it, so short glitches never commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
            db    <= IDLE;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : io_debounce
`default_nettype wire

// File: rtl/io_input_port.sv
`default_nettype none
// ============================================================================
// Module   : io_input_port
// Purpose  : Memory-mapped KEY/SW input peripheral on the IO page (addr[8]).
//            Debounces KEY[3:0] and SW[9:0] and latches press/release/change
//            events in a sticky write-1-to-clear register.
// Ports    : clk, reset (async active-low), key_raw[3:0] (active-low),
//            sw_raw[9:0], addr[31:0], wdata[31:0], memwrite,
//            rdata[31:0] (combinational read data),
//            irq (only when IO_IRQ_EN is defined)
// Map      : 0x110 RO key_db, 0x120 RO sw_db, 0x140 RW1C events,
//            0x180 RW irq_mask (IO_IRQ_EN only)
// Macro    : IO_IRQ_EN - adds irq output and irq_mask register
// Revision : 1.0  initial release
// ============================================================================
module io_input_port
    import io_map_pkg::*;
#(
    parameter int DB_CYCLES = 3,
    parameter int DB_CNT_W  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_raw,
    input  logic [9:0]  sw_raw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        memwrite,
    output logic [31:0] rdata
`ifdef IO_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [NUM_CH-1:0] IDLE_ALL = {SW_IDLE, KEY_IDLE};

    logic [NUM_CH-1:0]  raw_all;
    logic [NUM_CH-1:0]  db_all;
    logic [NUM_KEY-1:0] key_db;
    logic [NUM_SW-1:0]  sw_db;
    logic [NUM_KEY-1:0] key_db_q;
    logic [NUM_SW-1:0]  sw_db_q;
    logic [EVT_W-1:0]   events;
    logic [EVT_W-1:0]   evt_set;
    logic [EVT_W-1:0]   evt_clr;
    logic               page_sel;
    logic               unused_bits;

    assign raw_all  = {sw_raw, key_raw};
    assign key_db   = db_all[NUM_KEY-1:0];
    assign sw_db    = db_all[NUM_CH-1:NUM_KEY];
    assign page_sel = addr[IO_PAGE_BIT];

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_db
            io_debounce #(
                .DB_CYCLES (DB_CYCLES),
                .DB_CNT_W  (DB_CNT_W),
                .IDLE      (IDLE_ALL[g])
            ) u_db (
                .clk   (clk),
                .reset (reset),
                .raw   (raw_all[g]),
                .db    (db_all[g])
            );
        end
    endgenerate

    // Edge detection against the previous debounced level. The _q copies reset
    // to idle so that a key held through reset still produces a press event.
    always_comb begin
        evt_set = '0;
        evt_set[EVT_PRS_LO +: NUM_KEY] = key_db_q & ~key_db;
        evt_set[EVT_REL_LO +: NUM_KEY] = ~key_db_q & key_db;
        evt_set[EVT_CHG]               = |(sw_db_q ^ sw_db);
    end

    assign evt_clr = (memwrite && page_sel && addr[SEL_EVT]) ? wdata[EVT_W-1:0] : '0;

    // Set is OR-ed in after the clear so a same-cycle set always survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_db_q <= KEY_IDLE;
            sw_db_q  <= SW_IDLE;
            events   <= '0;
        end else begin
            key_db_q <= key_db;
            sw_db_q  <= sw_db;
            events   <= (events & ~evt_clr) | evt_set;
        end
    end

`ifdef IO_IRQ_EN
    logic [EVT_W-1:0] irq_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (memwrite && page_sel && addr[SEL_MASK]) begin
                irq_mask <= wdata[EVT_W-1:0];
            end
            irq <= |(events & irq_mask);
        end
    end
`endif

    // Read mux: lowest select bit wins when several are set.
    always_comb begin
        rdata = '0;
        if (page_sel) begin
            if (addr[SEL_KEY]) begin
                rdata = {28'b0, key_db};
            end else if (addr[SEL_SW]) begin
                rdata = {22'b0, sw_db};
            end else if (addr[SEL_EVT]) begin
                rdata = {23'b0, events};
`ifdef IO_IRQ_EN
            end else if (addr[SEL_MASK]) begin
                rdata = {23'b0, irq_mask};
`endif
            end
        end
    end

    assign unused_bits = ^{addr[31:9], addr[7], addr[3:0], wdata[31:9]};

endmodule : io_input_port
`default_nettype wire

// File: tb/tb_io_input_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_input_port
// Purpose  : Self-checking bench for io_input_port: directed scenarios plus a
//            randomized run checked against a cycle-level reference model.
// Macro    : IO_IRQ_EN - enables the irq port and mask-register scenarios
// Revision : 1.0  initial release
// ============================================================================
module tb_io_input_port;

    localparam int          DB       = 3;
    localparam logic [13:0] IDLE_ALL = 14'h000F;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  key_raw;
    logic [9:0]  sw_raw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        memwrite;
    logic [31:0] rdata;
`ifdef IO_IRQ_EN
    logic        irq;
`endif

    int total = 0;
    int bad   = 0;

    io_input_port #(
        .DB_CYCLES (DB),
        .DB_CNT_W  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_raw  (key_raw),
        .sw_raw   (sw_raw),
        .addr     (addr),
        .wdata    (wdata),
        .memwrite (memwrite),
        .rdata    (rdata)
`ifdef IO_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #10 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. Channel order: {sw[9:0], key[3:0]}. A debounced
    // level adopts the synchronised value once it has differed for DB
    // consecutive samples; events latch the db edges one clock later.
    // ------------------------------------------------------------------
    logic [13:0] m_s1, m_s2, m_db, m_dbq;
    int          m_run [14];
    logic [8:0]  m_ev, m_mask, t_set, t_clr;
    logic        m_irq;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_s1 = IDLE_ALL; m_s2 = IDLE_ALL; m_db = IDLE_ALL; m_dbq = IDLE_ALL;
            for (int i = 0; i < 14; i++) m_run[i] = 0;
            m_ev = '0; m_mask = '0; m_irq = 1'b0;
        end else begin
            m_irq = |(m_ev & m_mask);
`ifdef IO_IRQ_EN
            if (memwrite && addr[8] && addr[7]) m_mask = wdata[8:0];
`endif
            t_clr      = (memwrite && addr[8] && addr[6]) ? wdata[8:0] : 9'h0;
            t_set[3:0] = m_dbq[3:0] & ~m_db[3:0];
            t_set[7:4] = ~m_dbq[3:0] & m_db[3:0];
            t_set[8]   = (m_dbq[13:4] != m_db[13:4]);
            m_ev       = (m_ev & ~t_clr) | t_set;
            m_dbq      = m_db;
            for (int i = 0; i < 14; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_db[i]  = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {sw_raw, key_raw};
        end
    end

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (a[8]) begin
            if (a[4])      r = {28'b0, m_db[3:0]};
            else if (a[5]) r = {22'b0, m_db[13:4]};
            else if (a[6]) r = {23'b0, m_ev};
            else if (a[7]) r = {23'b0, m_mask};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Bus helpers (called at a negedge; reads settle 1 time unit).
    // ------------------------------------------------------------------
    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr     = a;
        wdata    = d;
        memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
        wdata    = '0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0; key_raw = 4'hF; sw_raw = '0; addr = '0; wdata = '0; memwrite = 1'b0;
        settle(3);
        reset = 1'b1;
        sw_raw = 10'h3C3; key_raw = 4'h7;
        settle(8);
        key_raw = 4'h5;            // KEY1 starts debouncing, reset hits mid-way
        settle(3);
        reset = 1'b0;
        #1;
        rd(32'h110, d); total++;
        if (d !== 32'h0000000F) begin bad++; $display("FAIL reset_key: got %h want %h", d, 32'hF); end
        rd(32'h120, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_sw: got %h want %h", d, 32'h0); end
        rd(32'h140, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_evt: got %h want %h", d, 32'h0); end
`ifdef IO_IRQ_EN
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
        settle(2);
        sw_raw = '0;
        reset  = 1'b1;             // keys 3 and 1 still held (raw 0x5)
        settle(4);
        rd(32'h110, d); total++;
        if (d !== 32'hF) begin bad++; $display("FAIL held_key_early: got %h want %h", d, 32'hF); end
        settle(1);
        rd(32'h110, d); total++;
        if (d !== 32'h5) begin bad++; $display("FAIL held_key_db: got %h want %h", d, 32'h5); end
        settle(1);
        rd(32'h140, d); total++;
        if (d !== 32'h00A) begin bad++; $display("FAIL held_key_prs: got %h want %h", d, 32'h00A); end
        key_raw = 4'hF;
        settle(8);
        wr(32'h140, 32'h1FF);
    endtask

    task automatic test_clean_press();
        logic [31:0] d;
        key_raw[1] = 1'b0;
        settle(4);
        rd(32'h110, d); total++;
        if (d !== 32'hF) begin bad++; $display("FAIL press_4th_edge: got %h want %h", d, 32'hF); end
        settle(1);
        rd(32'h110, d); total++;
        if (d !== 32'hD) begin bad++; $display("FAIL press_5th_edge: got %h want %h", d, 32'hD); end
        rd(32'h140, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL press_evt_early: got %h want %h", d, 32'h0); end
        settle(1);
        rd(32'h140, d); total++;
        if (d !== 32'h002) begin bad++; $display("FAIL press_evt: got %h want %h", d, 32'h002); end
        key_raw[1] = 1'b1;
        settle(6);
        rd(32'h140, d); total++;
        if (d !== 32'h022) begin bad++; $display("FAIL release_evt: got %h want %h", d, 32'h022); end
        rd(32'h110, d); total++;
        if (d !== 32'hF) begin bad++; $display("FAIL release_key: got %h want %h", d, 32'hF); end
        wr(32'h140, 32'h1FF);
    endtask

    task automatic test_bounce();
        logic [31:0] d;
        for (int k = 0; k < 5; k++) begin
            key_raw[0] = 1'b0; settle(2);
            key_raw[0] = 1'b1; settle(1);
            rd(32'h110, d); total++;
            if (d !== 32'hF) begin bad++; $display("FAIL bounce_key_%0d: got %h want %h", k, d, 32'hF); end
        end
        settle(6);
        rd(32'h110, d); total++;
        if (d !== 32'hF) begin bad++; $display("FAIL bounce_key_final: got %h want %h", d, 32'hF); end
        rd(32'h140, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL bounce_evt: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_w1c();
        logic [31:0] d;
        key_raw = 4'hC; sw_raw[0] = 1'b1;
        settle(7);
        rd(32'h140, d); total++;
        if (d !== 32'h103) begin bad++; $display("FAIL w1c_setup: got %h want %h", d, 32'h103); end
        wr(32'h140, 32'h001);
        rd(32'h140, d); total++;
        if (d !== 32'h102) begin bad++; $display("FAIL w1c_clear: got %h want %h", d, 32'h102); end
        sw_raw[3] = 1'b1;
        settle(5);
        wr(32'h140, 32'h100);      // lands on the same edge sw_chg re-sets
        rd(32'h140, d); total++;
        if (d !== 32'h102) begin bad++; $display("FAIL w1c_collision: got %h want %h", d, 32'h102); end
        wr(32'h140, 32'h100);
        rd(32'h140, d); total++;
        if (d !== 32'h002) begin bad++; $display("FAIL w1c_plain: got %h want %h", d, 32'h002); end
        key_raw = 4'hF; sw_raw = '0;
        settle(8);
        wr(32'h140, 32'h1FF);
        rd(32'h140, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL w1c_all: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_switch();
        logic [31:0] d;
        sw_raw = 10'h2A5;
        settle(4);
        rd(32'h120, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL sw_early: got %h want %h", d, 32'h0); end
        settle(1);
        rd(32'h120, d); total++;
        if (d !== 32'h2A5) begin bad++; $display("FAIL sw_db: got %h want %h", d, 32'h2A5); end
        rd(32'h110, d); total++;
        if (d !== 32'hF) begin bad++; $display("FAIL sw_key_unaffected: got %h want %h", d, 32'hF); end
        settle(1);
        rd(32'h140, d); total++;
        if (d !== 32'h100) begin bad++; $display("FAIL sw_chg: got %h want %h", d, 32'h100); end
        rd(32'h130, d); total++;   // bit4 beats bit5
        if (d !== 32'hF) begin bad++; $display("FAIL read_priority: got %h want %h", d, 32'hF); end
        sw_raw = '0;
        settle(8);
        wr(32'h140, 32'h1FF);
    endtask

    task automatic test_ro_write();
        logic [31:0] d;
        wr(32'h110, 32'h0);
        wr(32'h120, 32'h3FF);
        rd(32'h110, d); total++;
        if (d !== 32'hF) begin bad++; $display("FAIL ro_key: got %h want %h", d, 32'hF); end
        rd(32'h120, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL ro_sw: got %h want %h", d, 32'h0); end
        rd(32'h050, d); total++;   // off-page
        if (d !== 32'h0) begin bad++; $display("FAIL off_page: got %h want %h", d, 32'h0); end
        wr(32'h180, 32'h1FF);
        rd(32'h180, d); total++;
`ifdef IO_IRQ_EN
        if (d !== 32'h1FF) begin bad++; $display("FAIL mask_rw: got %h want %h", d, 32'h1FF); end
        wr(32'h180, 32'h0);
`else
        if (d !== 32'h0) begin bad++; $display("FAIL mask_absent: got %h want %h", d, 32'h0); end
`endif
    endtask

`ifdef IO_IRQ_EN
    task automatic test_irq();
        wr(32'h180, 32'h004);
        key_raw[2] = 1'b0;
        settle(6);                 // key_prs[2] sets on this edge
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want 0", irq); end
        settle(1);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL irq_set: got %b want 1", irq); end
        wr(32'h140, 32'h004);
        settle(1);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", irq); end
        key_raw = 4'hF;
        settle(8);
        wr(32'h140, 32'h1FF);
        key_raw[0] = 1'b0;
        settle(9);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_unmasked: got %b want 0", irq); end
        key_raw = 4'hF;
        settle(8);
        wr(32'h140, 32'h1FF);
        wr(32'h180, 32'h0);
    endtask
`endif

    task automatic test_random();
        logic [31:0] d, a;
        logic [31:0] extra [5];
        logic [13:0] r;
        extra[0] = 32'h180; extra[1] = 32'h100; extra[2] = 32'h050;
        extra[3] = 32'h170; extra[4] = 32'h160;
        r = {sw_raw, key_raw};
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 13)] ^= 1'b1;
            key_raw = r[3:0];
            sw_raw  = r[13:4];
            if ($urandom_range(0, 11) == 0) begin
                wr(32'h140, {23'b0, 9'($urandom)});
            end else if ($urandom_range(0, 19) == 0) begin
                wr(32'h180, {23'b0, 9'($urandom)});
            end else if ($urandom_range(0, 29) == 0) begin
                wr(32'h110, $urandom);
            end else begin
                @(negedge clk);
                rd(32'h110, d); total++;
                if (d !== model_rd(32'h110)) begin bad++; $display("FAIL rnd_key c=%0d: got %h want %h", c, d, model_rd(32'h110)); end
                rd(32'h120, d); total++;
                if (d !== model_rd(32'h120)) begin bad++; $display("FAIL rnd_sw c=%0d: got %h want %h", c, d, model_rd(32'h120)); end
                rd(32'h140, d); total++;
                if (d !== model_rd(32'h140)) begin bad++; $display("FAIL rnd_evt c=%0d: got %h want %h", c, d, model_rd(32'h140)); end
                a = extra[c % 5];
                rd(a, d); total++;
                if (d !== model_rd(a)) begin bad++; $display("FAIL rnd_rd_%h c=%0d: got %h want %h", a, c, d, model_rd(a)); end
`ifdef IO_IRQ_EN
                total++;
                if (irq !== m_irq) begin bad++; $display("FAIL rnd_irq c=%0d: got %b want %b", c, irq, m_irq); end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_w1c();
        test_switch();
        test_ro_write();
`ifdef IO_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_io_input_port
`default_nettype wire
